// File: rtl/ota_trim_cal_ctrl.sv
// OTA offset-trim calibrator: input short, SAR search over the trim code with majority-voted
// comparator decisions, then RUN with the result. Optional macro: OTA_CAL_PERIODIC_EN (auto-recal).
module ota_trim_cal_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 8,
  parameter int NSAMP      = 3
`ifdef OTA_CAL_PERIODIC_EN
  , parameter int PERIOD   = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cal_start,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] trim_code,
  output logic              ota_en,
  output logic              in_short,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_fail
);

  localparam int CNT_MAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ONES_W  = $clog2(NSAMP + 1);
  localparam int BIT_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SHORT, S_TRIAL, S_SAMPLE, S_DECIDE, S_RUN
  } state_t;

  state_t              state_q, state_next;
  logic [1:0]          sync_q;
  logic                cmp_sync;
  logic [CNT_W-1:0]    cnt_q;
  logic [ONES_W-1:0]   ones_q;
  logic [BIT_W-1:0]    bit_q, bit_next;
  logic [TRIM_W-1:0]   trim_q, trim_next;
  logic                fail_q, fail_next;
  logic                recal;

  assign cmp_sync = sync_q[1];

`ifdef OTA_CAL_PERIODIC_EN
  localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [PER_W-1:0] per_q;

  // Counts RUN cycles only; any other state holds it at zero so RUN entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                per_q <= '0;
    else if (state_q != S_RUN) per_q <= '0;
    else                       per_q <= per_q + 1'b1;
  end

  assign recal = (per_q == PER_W'(PERIOD - 1));
`else
  assign recal = 1'b0;
`endif

  always_comb begin
    state_next = state_q;
    trim_next  = trim_q;
    fail_next  = fail_q;
    bit_next   = bit_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (cal_start || (state_q == S_RUN && recal)) begin
          state_next = S_SHORT;
          trim_next  = '0;
          fail_next  = 1'b0;
        end
      end
      S_SHORT: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_next = S_TRIAL;
          bit_next   = BIT_W'(TRIM_W - 1);
          trim_next[TRIM_W-1] = 1'b1;
        end
      end
      S_TRIAL: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (cnt_q == CNT_W'(NSAMP - 1)) state_next = S_DECIDE;
      end
      S_DECIDE: begin
        // Majority high means the comparator says the trim is too large.
        if (ones_q > ONES_W'(NSAMP / 2)) trim_next[bit_q] = 1'b0;
        if (bit_q == '0) begin
          state_next = S_RUN;
          fail_next  = (trim_next == '0) || (trim_next == '1);
        end else begin
          state_next = S_TRIAL;
          bit_next   = bit_q - 1'b1;
          trim_next[bit_q - 1'b1] = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Disable wins over everything but keeps the last code and fail flag.
    if (!ena) begin
      state_next = S_IDLE;
      trim_next  = trim_q;
      fail_next  = fail_q;
      bit_next   = bit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      trim_q  <= MIDSCALE;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      sync_q  <= {sync_q[0], cmp_in};
      bit_q   <= bit_next;
      trim_q  <= trim_next;
      fail_q  <= fail_next;
      if (state_next != state_q || state_q == S_IDLE || state_q == S_RUN) cnt_q <= '0;
      else                                                                 cnt_q <= cnt_q + 1'b1;
      if (state_q != S_SAMPLE) ones_q <= '0;
      else if (cmp_sync)       ones_q <= ones_q + 1'b1;
    end
  end

  always_comb begin
    trim_code = trim_q;
    cal_fail  = fail_q;
    ota_en    = (state_q != S_IDLE);
    in_short  = (state_q != S_IDLE) && (state_q != S_RUN);
    cal_busy  = in_short;
    cal_done  = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_ota_trim_cal_ctrl.sv
// Directed bench for ota_trim_cal_ctrl: table of full calibrations against a threshold
// comparator model, plus hand sequences for reset, enable and restart corner cases.
module tb_ota_trim_cal_ctrl;

  logic       clk, rst_n, ena, cal_start, cmp_in;
  logic [5:0] trim_code;
  logic       ota_en, in_short, cal_busy, cal_done, cal_fail;

  logic [6:0] thr_r;
  logic       cmp_model, cmp_inv;
  int         checks, failures;

  ota_trim_cal_ctrl #(
    .TRIM_W(6), .SETTLE_CYC(8), .NSAMP(3)
`ifdef OTA_CAL_PERIODIC_EN
    , .PERIOD(64)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cal_start(cal_start), .cmp_in(cmp_in),
    .trim_code(trim_code), .ota_en(ota_en), .in_short(in_short),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparator model: high when trim is at or above the threshold, one cycle late.
  always @(posedge clk) cmp_model <= ({1'b0, trim_code} >= thr_r);
  assign cmp_in = cmp_model ^ cmp_inv;

  typedef struct {
    logic [6:0] thr;
    logic       inv;
    logic       restart;
    logic [5:0] exp_trim;
    logic       exp_fail;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse cal_start, then run until busy drops; returns busy length and short violations.
  task automatic run_cal(input logic inv, input logic restart,
                         output int busy_cyc, output int short_err);
    int t;
    busy_cyc  = 0;
    short_err = 0;
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    t = 1;
    while (cal_busy && t < 200) begin
      busy_cyc++;
      if (!in_short || !ota_en || cal_done) short_err++;
      cal_start = restart && (t == 40);
      cmp_inv   = inv && (t >= 15) && (t % 12 == 3);
      step();
      t++;
    end
    cal_start = 1'b0;
    cmp_inv   = 1'b0;
  endtask

  initial begin
    int b, se, n;
    checks = 0; failures = 0;
    rst_n = 1'b0; ena = 1'b1; cal_start = 1'b0; cmp_inv = 1'b0; thr_r = 7'd43;

    vecs[0] = '{thr: 7'd64, inv: 1'b0, restart: 1'b0, exp_trim: 6'h3F, exp_fail: 1'b1};
    vecs[1] = '{thr: 7'd0,  inv: 1'b0, restart: 1'b0, exp_trim: 6'h00, exp_fail: 1'b1};
    vecs[2] = '{thr: 7'd43, inv: 1'b0, restart: 1'b0, exp_trim: 6'h2A, exp_fail: 1'b0};
    vecs[3] = '{thr: 7'd43, inv: 1'b1, restart: 1'b0, exp_trim: 6'h2A, exp_fail: 1'b0};
    vecs[4] = '{thr: 7'd63, inv: 1'b0, restart: 1'b0, exp_trim: 6'h3E, exp_fail: 1'b0};
    vecs[5] = '{thr: 7'd1,  inv: 1'b0, restart: 1'b0, exp_trim: 6'h00, exp_fail: 1'b1};
    vecs[6] = '{thr: 7'd32, inv: 1'b0, restart: 1'b1, exp_trim: 6'h1F, exp_fail: 1'b0};

    repeat (3) step();
    check("reset_trim", trim_code, 6'h20);
    check("reset_ota_en", ota_en, 0);
    check("reset_in_short", in_short, 0);
    check("reset_busy", cal_busy, 0);
    check("reset_done", cal_done, 0);
    check("reset_fail", cal_fail, 0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 7; i++) begin
      thr_r = vecs[i].thr;
      repeat (3) step();
      run_cal(vecs[i].inv, vecs[i].restart, b, se);
      check($sformatf("v%0d_busy_len", i), b, 80);
      check($sformatf("v%0d_short_busy", i), se, 0);
      check($sformatf("v%0d_trim", i), trim_code, vecs[i].exp_trim);
      check($sformatf("v%0d_fail", i), cal_fail, vecs[i].exp_fail);
      check($sformatf("v%0d_done", i), cal_done, 1);
      check($sformatf("v%0d_run_ota", i), {ota_en, in_short}, 2'b10);
    end

`ifdef OTA_CAL_PERIODIC_EN
    n = 0;
    while (cal_done && n < 200) begin n++; step(); end
    check("period_first_run_len", n, 64);
    b = 0;
    while (cal_busy && b < 200) begin b++; step(); end
    check("period_busy_len", b, 80);
    n = 0;
    while (cal_done && n < 200) begin
      n++;
      if (n == 64) cal_start = 1'b1;
      step();
      cal_start = 1'b0;
    end
    check("period_coincident_run_len", n, 64);
    b = 0;
    while (cal_busy && b < 200) begin b++; step(); end
    check("period_coincident_busy", b, 80);
    n = 0;
    while (cal_done && n < 200) begin n++; step(); end
    check("period_no_double_cal", n, 64);
    while (cal_busy) step();
`else
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (cal_busy || !cal_done) n++;
      step();
    end
    check("no_auto_recal", n, 0);
`endif

    // Enable drop mid-calibration: code keeps its partial value, block goes idle.
    thr_r = 7'd43;
    repeat (3) step();
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    repeat (29) step();
    check("ena_pre_trim", trim_code, 6'h30);
    ena = 1'b0;
    step();
    check("ena_busy", cal_busy, 0);
    check("ena_ota_in", {ota_en, in_short, cal_done}, 3'b000);
    check("ena_trim_kept", trim_code, 6'h30);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    check("ena_start_blocked", cal_busy, 0);
    ena = 1'b1;
    repeat (3) step();
    check("ena_no_queue", cal_busy, 0);

    // Asynchronous reset while trialling bit 3.
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    repeat (34) step();
    check("rst_pre_trim", trim_code, 6'h28);
    rst_n = 1'b0;
    #1;
    check("rst_async_trim", trim_code, 6'h20);
    check("rst_async_flags", {ota_en, in_short, cal_busy, cal_done, cal_fail}, 5'b0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_idle_flags", {ota_en, in_short, cal_busy, cal_done, cal_fail}, 5'b0);
    check("rst_idle_trim", trim_code, 6'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ota_trim_cal_ctrl.md
Name: ota_trim_cal_ctrl

Overview:
- Sequencer and offset-trim calibrator for the gate-level digital OTA/comparator cell.
- On request: enables the OTA, shorts its inputs, and runs a successive-approximation (SAR) search over a trim DAC code.
  - Each decision uses the majority of several synchronized comparator samples.
- Then releases the inputs and holds the OTA in normal operation with the calibrated code.
- Sits between the TT user-interface pins (ui_in/uo_out) and the analog OTA macro.

Parameters:
- TRIM_W, 6: trim code width in bits, 2..8.
- SETTLE_CYC, 8: analog settle cycles after any input-short or trim change, ≥1.
- NSAMP, 3: comparator samples per SAR decision. Must be odd, 1..15.
- PERIOD, 4096: recalibration interval in RUN cycles. Used only with OTA_CAL_PERIODIC_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable. Low forces IDLE, synchronously.
- cal_start  in  1  single-cycle calibration request
- cmp_in  in  1  raw OTA output (asynchronous to clk)
- trim_code  out  TRIM_W  trim DAC code to the OTA
- ota_en  out  1  OTA enable / output-buffer enable
- in_short  out  1  shorts OTA inputs Vip/Vin for calibration
- cal_busy  out  1  high during calibration
- cal_done  out  1  high while in RUN after a completed calibration
- cal_fail  out  1  sticky: last result saturated (all-0 or all-1)

Behaviour:
- Reset values: trim_code = midscale (MSB=1, others 0); ota_en = 0; in_short = 0; cal_busy = 0; cal_done = 0; cal_fail = 0; FSM = IDLE; counters = 0.
- cmp_in passes through a 2-flop synchronizer. Sample latency is 2 cycles. Sampling uses the synchronized value only.
- States and outputs:
  - IDLE: ota_en = 0, in_short = 0. cal_start → SHORT.
  - SHORT: ota_en = 1, in_short = 1, trim_code cleared to 0. Lasts SETTLE_CYC cycles. Then bit index = TRIM_W-1 → TRIAL.
  - TRIAL: on entry, set trim_code[bit] = 1. Hold SETTLE_CYC cycles → SAMPLE.
  - SAMPLE: NSAMP cycles; count synchronized ones → DECIDE.
  - DECIDE (1 cycle): if ones > NSAMP/2, clear trim_code[bit] (cmp high = trim too large), else keep it.
    - If bit == 0 → RUN; else bit-1 → TRIAL.
  - RUN: ota_en = 1, in_short = 0, cal_done = 1. trim_code held. cal_start → SHORT (recalibrate).
- cal_busy is high in SHORT/TRIAL/SAMPLE/DECIDE. Busy duration is exactly SETTLE_CYC + TRIM_W*(SETTLE_CYC+NSAMP+1) cycles, which is 80 at defaults.
- The state register leaves IDLE/RUN on the edge that samples cal_start.
- cal_start while busy is ignored (no queueing).
- cal_done falls on entry to SHORT.
- cal_fail:
  - Cleared on entry to SHORT.
  - Set on RUN entry if final trim_code == 0 or == all-ones.
  - Holds until the next calibration or reset.
- ena low in any state: next cycle IDLE; busy/done/ota_en/in_short = 0; trim_code and cal_fail retained.
  - ena has priority over cal_start.
- Asynchronous reset mid-calibration: immediate return to reset values, including midscale trim. No partial result is kept.
- Ones counter width is clog2(NSAMP+1). It never wraps.

Optional Feature:
- Macro: OTA_CAL_PERIODIC_EN.
- Defined: a PERIOD-cycle counter runs only in RUN and is cleared on RUN entry.
  - On reaching PERIOD-1 it triggers automatic recalibration (RUN → SHORT) exactly as cal_start does.
  - A simultaneous cal_start causes one calibration, not two.
- Undefined: no counter. RUN is left only by cal_start, ena low, or reset.

Test Plan:
- Defaults, cmp_in tied 0, cal_start pulse:
  - cal_busy high exactly 80 cycles.
  - trim_code = 6'h3F, cal_done = 1, cal_fail = 1.
  - in_short = 1 throughout busy, 0 in RUN.
- cmp_in tied 1 → trim_code = 6'h00, cal_fail = 1.
- Behavioural model cmp_in = (trim_code ≥ 43), applied after 1-cycle delay → trim_code = 6'h2A, cal_fail = 0, cal_done = 1.
- Majority filter: model from the previous test, plus one of three samples inverted in every SAMPLE window → result still 6'h2A.
- Robustness:
  - rst_n low for 1 cycle at bit 3 of a calibration → trim_code = 6'h20, all flags 0, FSM in IDLE.
  - ena low mid-calibration → IDLE next cycle, trim_code retained.
  - cal_start while busy → no effect on duration.
- With OTA_CAL_PERIODIC_EN, PERIOD = 64: after RUN entry, automatic recalibration starts at RUN cycle 64.
  - cal_start on that same cycle yields exactly one 80-cycle busy window.
  - Without the macro, no recalibration occurs over 1000 cycles.
